// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and sizing helpers for the fifo_mono buffer.
// Imported by the FIFO interfaces and the FIFO body.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;

    // Keep a pointer at least one bit wide so a degenerate depth still elaborates.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_interface.sv
// fifo_interface: producer and consumer bundles for fifo_mono.
// Each bundle carries a DUT-side modport and a bench-side modport.
interface write_interface
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input logic clk
);

    logic [WIDTH-1:0] din;
    logic             write;
    logic             full;

    modport fifo (
        input  din,
        input  write,
        output full
    );

    clocking cb_fifo @(posedge clk);
        output din, write;
        input  full;
    endclocking

    modport tb_fifo (
        input  clk,
        output din,
        output write,
        input  full
    );

endinterface

interface read_interface
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input logic clk
);

    logic [WIDTH-1:0] dout;
    logic             read;
    logic             empty;

    modport fifo (
        input  read,
        output dout,
        output empty
    );

    clocking cb_fifo @(posedge clk);
        output read;
        input  dout, empty;
    endclocking

    modport tb_fifo (
        input  clk,
        output read,
        input  dout,
        input  empty
    );

endinterface

// File: rtl/fifo_mono.sv
// fifo_mono: single-clock show-ahead FIFO between one producer
// and one consumer.
module fifo_mono
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic           clk,
    input logic           rst,
    write_interface.fifo  write_port,
    read_interface.fifo   read_port
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic empty;
    logic full;
    logic rd_ok;
    logic wr_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A write into a full FIFO is still taken when the head is popped
    // on the same edge.
    assign rd_ok = read_port.read && !empty;
    assign wr_ok = write_port.write && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= write_port.din;
        end
    end

    assign write_port.full = full;
    assign read_port.empty = empty;
    assign read_port.dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fifo_mono.sv
// tb_fifo_mono: directed vectors for fifo_mono with hand-computed
// expected values.
module tb_fifo_mono;

    import fifo_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic rst;

    int nvec;
    int nbad;

    write_interface #(.WIDTH(W)) wp (.clk(clk));
    read_interface  #(.WIDTH(W)) rp (.clk(clk));

    fifo_mono #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write_port(wp),
        .read_port (rp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        wp.din   = v;
        wp.write = 1'b1;
        tick();
        wp.write = 1'b0;
    endtask

    logic [W-1:0] exp_q[$];

    initial begin
        nvec = 0;
        nbad = 0;
        rst      = 1'b0;
        wp.din   = '0;
        wp.write = 1'b0;
        rp.read  = 1'b0;

        // 1: reset held two cycles
        tick();
        tick();
        chk("rst_empty", 32'(rp.empty), 32'd1);
        chk("rst_full", 32'(wp.full), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_empty", 32'(rp.empty), 32'd1);
        chk("post_rst_dout", 32'(rp.dout), 32'd0);

        // 2: single write, visible right after the edge
        push(8'd1);
        chk("w1_empty", 32'(rp.empty), 32'd0);
        chk("w1_dout", 32'(rp.dout), 32'd1);
        tick();
        chk("w1_idle_dout", 32'(rp.dout), 32'd1);
        chk("w1_idle_full", 32'(wp.full), 32'd0);

        // 3: fill, then a dropped write
        push(8'd2);
        push(8'd3);
        chk("w3_full", 32'(wp.full), 32'd0);
        push(8'd4);
        chk("w4_full", 32'(wp.full), 32'd1);
        push(8'd9);
        chk("drop_full", 32'(wp.full), 32'd1);
        chk("drop_head", 32'(rp.dout), 32'd1);

        // 4: drain four in a row
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        rp.read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_dout", i), 32'(rp.dout),
                32'(exp_q[i]));
            tick();
            if (i == 0) chk("drain_full", 32'(wp.full), 32'd0);
        end
        rp.read = 1'b0;
        chk("drain_empty", 32'(rp.empty), 32'd1);
        chk("drain_dout0", 32'(rp.dout), 32'd0);

        // 5: write, write+read, read
        push(8'd5);
        chk("s5_dout5", 32'(rp.dout), 32'd5);
        chk("s5_empty", 32'(rp.empty), 32'd0);
        wp.din   = 8'd6;
        wp.write = 1'b1;
        rp.read  = 1'b1;
        tick();
        wp.write = 1'b0;
        chk("s5_dout6", 32'(rp.dout), 32'd6);
        chk("s5_full", 32'(wp.full), 32'd0);
        tick();
        rp.read = 1'b0;
        chk("s5_empty_end", 32'(rp.empty), 32'd1);

        // 6: full with simultaneous read+write
        push(8'd1);
        push(8'd2);
        push(8'd3);
        push(8'd4);
        chk("s6_full", 32'(wp.full), 32'd1);
        wp.din   = 8'd7;
        wp.write = 1'b1;
        rp.read  = 1'b1;
        tick();
        wp.write = 1'b0;
        chk("s6_rw_full", 32'(wp.full), 32'd1);
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd7};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s6_drain%0d", i), 32'(rp.dout),
                32'(exp_q[i]));
            tick();
        end
        rp.read = 1'b0;
        chk("s6_empty", 32'(rp.empty), 32'd1);

        // 7: read while empty leaves the read pointer alone
        rp.read = 1'b1;
        tick();
        rp.read = 1'b0;
        chk("s7_empty", 32'(rp.empty), 32'd1);
        chk("s7_dout", 32'(rp.dout), 32'd0);
        push(8'h8a);
        chk("s7_head", 32'(rp.dout), 32'h8a);
        push(8'h8b);
        rp.read = 1'b1;
        tick();
        chk("s7_next", 32'(rp.dout), 32'h8b);
        tick();
        rp.read = 1'b0;
        chk("s7_drained", 32'(rp.empty), 32'd1);

        // 8: asynchronous reset between edges while full
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("s8_full_pre", 32'(wp.full), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("s8_async_empty", 32'(rp.empty), 32'd1);
        chk("s8_async_full", 32'(wp.full), 32'd0);
        chk("s8_async_dout", 32'(rp.dout), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        push(8'h55);
        chk("s8_after_head", 32'(rp.dout), 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/fifo_mono.md
Name: fifo_mono

Overview:
Single-clock synchronous FIFO with first-word-fall-through (show-ahead) read data. It buffers WIDTH-bit words between one producer and one consumer in the same clock domain. The producer connects through a write_interface bundle (din/write/full) and the consumer through a read_interface bundle (dout/read/empty). It serves as the basic buffering element of the dataflow fabric.

Parameters:
WIDTH  8  data word width in bits (>=1)
DEPTH  4  number of storage entries (>=2; need not be a power of two)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
write_port.din  input  WIDTH  write data
write_port.write  input  1  write request
write_port.full  output  1  FIFO holds DEPTH entries
read_port.read  input  1  read (pop) request
read_port.dout  output  WIDTH  head-of-queue data
read_port.empty  output  1  FIFO holds 0 entries

Interface bundles:
- write_interface #(WIDTH) and read_interface #(WIDTH) each take clk as an interface port.
- Each provides modport fifo (DUT side) and modport tb_fifo with clocking block cb_fifo @(posedge clk).
- write_interface cb_fifo: outputs din and write; input full.
- read_interface cb_fifo: output read; inputs dout and empty.

Behaviour:
- Reset (rst low, asynchronous): write and read pointers = 0, occupancy count = 0, empty = 1, full = 0. Storage contents are not cleared. Reset mid-operation discards all contents immediately.
- State: storage array mem[DEPTH], wr_ptr, rd_ptr (clog2(DEPTH) bits), count (clog2(DEPTH+1) bits).
- Pointers wrap from DEPTH-1 to 0.
- Write acceptance: on a rising edge with write=1 and (full=0, or full=1 with read accepted the same edge): mem[wr_ptr] <= din, wr_ptr advances.
- Otherwise a write while full is dropped silently. State is unchanged and no error is flagged.
- Read acceptance: on a rising edge with read=1 and empty=0: rd_ptr advances.
- A read while empty is ignored; there is no bypass of same-cycle write data.
- dout is combinational: dout = mem[rd_ptr] whenever empty=0, and 0 when empty=1.
  - The head word is visible before read is asserted (show-ahead).
  - After an accepted read, the next word appears the following cycle.
- count: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
- Flags are derived from count: empty = (count==0), full = (count==DEPTH). Both update in the cycle after the causing edge.
- Latency: a word written at edge N appears on dout (with empty=0) after edge N, assuming it is at the head.
- Simultaneous read+write:
  - Non-empty and non-full: both are performed.
  - Full: both are performed, full stays 1.
  - Empty: only the write is performed.

Decomposition:
- Package fifo_pkg: default WIDTH/DEPTH constants and a pointer-width localparam helper based on clog2.
- write_interface and read_interface live in a shared fifo_interface file.
- No sub-module is required. Pointer/count logic stays inline in fifo_mono.

Test Plan:
1. Reset for 2 cycles then release -> empty=1, full=0.
2. Write 1 (one cycle), idle one cycle -> empty=0, dout=1.
3. Write 2, 3, 4 back-to-back -> full=1 after the 4th write; a further write of 9 while full is dropped (contents remain 1,2,3,4).
4. Assert read for 4 consecutive cycles -> dout is 1, 2, 3, 4 on successive cycles; full=0 after the first read; empty=1 after the fourth.
5. Write 5, then write 6 with read=1, then read=1 alone -> dout=5 with empty=0, then dout=6 with full=0, then empty=1.
6. Fill to 4 entries, then assert read+write (din=7) together -> full stays 1; the drain order is 2,3,4,7.
7. Read while empty -> no pointer change, empty=1, dout=0.
8. Assert rst low mid-fill (asynchronous, between edges) -> empty=1 and full=0 immediately.
